// File: rtl/fetch_control.sv
// Fetch-stage sequencer: owns the PC, requests instructions from the I-cache,
// and presents each delivered instruction to the fetch pipeline registers.
// Decode back-pressure (stall) holds a returned word until it is accepted.
// A branch redirect (flush) overrides everything else.
module fetch_control #(
    parameter int unsigned WORD_SIZE = 32,
    parameter logic [WORD_SIZE-1:0] RESET_PC = WORD_SIZE'(32'h1000)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 icache_req,
    output logic [WORD_SIZE-1:0] icache_addr,
    input  logic                 icache_ready,
    input  logic [WORD_SIZE-1:0] icache_data,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    output logic [WORD_SIZE-1:0] pc_out,
    output logic [WORD_SIZE-1:0] instruction_out,
    output logic                 active_out,
    output logic                 flush_out
);

    localparam int unsigned W = WORD_SIZE;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   pc_q, pc_d;
    logic [W-1:0]   buf_q, buf_d;
    logic           req_d;
    logic [W-1:0]   addr_d;
    logic [W-1:0]   pc_out_d;
    logic [W-1:0]   instr_d;
    logic           active_d;
    logic           flush_d;

    logic [W-1:0]   pc_inc;
    logic [W-1:0]   redirect_target;
    state_t         resume;

    // Sequential PC increment (wraps modulo 2^W) and word-aligned redirect target
    assign pc_inc          = pc_q + W'(4);
    assign redirect_target = {redirect_pc[W-1:2], 2'b00};
    assign resume          = start ? S_REQ : S_IDLE;

    // Next-state and next-output logic; redirect takes priority over everything
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        buf_d    = buf_q;
        req_d    = icache_req;
        addr_d   = icache_addr;
        pc_out_d = pc_out;
        instr_d  = instruction_out;
        active_d = 1'b0;
        flush_d  = 1'b0;

        if (redirect_valid) begin
            pc_d    = redirect_target;
            flush_d = 1'b1;
            case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_REQ,
                S_HOLD: state_d = resume;
                S_WAIT,
                S_DRAIN: begin
                    // An outstanding request must complete before a new one is issued
                    if (icache_ready) begin
                        req_d   = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_REQ;
                    end
                end
                S_REQ: begin
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (icache_ready) begin
                        req_d = 1'b0;
                        if (!stall) begin
                            pc_out_d = pc_q;
                            instr_d  = icache_data;
                            active_d = 1'b1;
                            pc_d     = pc_inc;
                            state_d  = resume;
                        end else begin
                            buf_d   = icache_data;
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        pc_out_d = pc_q;
                        instr_d  = buf_q;
                        active_d = 1'b1;
                        pc_d     = pc_inc;
                        state_d  = resume;
                    end
                end
                S_DRAIN: begin
                    if (icache_ready) begin
                        req_d   = 1'b0;
                        state_d = resume;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State, PC, hold buffer and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            pc_q            <= RESET_PC;
            buf_q           <= '0;
            icache_req      <= 1'b0;
            icache_addr     <= '0;
            pc_out          <= '0;
            instruction_out <= '0;
            active_out      <= 1'b0;
            flush_out       <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            buf_q           <= buf_d;
            icache_req      <= req_d;
            icache_addr     <= addr_d;
            pc_out          <= pc_out_d;
            instruction_out <= instr_d;
            active_out      <= active_d;
            flush_out       <= flush_d;
        end
    end

endmodule

// File: tb/tb_fetch_control.sv
// Bench for fetch_control: transaction-level reference model feeding a scoreboard,
// randomized cache latency / stall / redirect, plus directed scenarios.
`timescale 1ns/1ps
module tb_fetch_control;

    localparam int unsigned W = 32;
    localparam logic [W-1:0] RST_PC  = 32'h0000_1000;
    localparam logic [W-1:0] WRAP_PC = 32'hFFFF_FFFC;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         icache_ready = 1'b0;
    logic [W-1:0] icache_data = '0;
    logic         stall = 1'b0;
    logic         redirect_valid = 1'b0;
    logic [W-1:0] redirect_pc = '0;
    logic         icache_req, active_out, flush_out;
    logic [W-1:0] icache_addr, pc_out, instruction_out;

    logic         w_ready = 1'b0;
    logic [W-1:0] w_data = '0;
    logic         w_req, w_act, w_flush;
    logic [W-1:0] w_addr, w_pc, w_instr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_control #(.WORD_SIZE(W), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .icache_req(icache_req), .icache_addr(icache_addr),
        .icache_ready(icache_ready), .icache_data(icache_data),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .pc_out(pc_out), .instruction_out(instruction_out),
        .active_out(active_out), .flush_out(flush_out)
    );

    fetch_control #(.WORD_SIZE(W), .RESET_PC(WRAP_PC)) u_wrap (
        .clk(clk), .rst_n(rst_n), .start(1'b1),
        .icache_req(w_req), .icache_addr(w_addr),
        .icache_ready(w_ready), .icache_data(w_data),
        .stall(1'b0), .redirect_valid(1'b0), .redirect_pc('0),
        .pc_out(w_pc), .instruction_out(w_instr),
        .active_out(w_act), .flush_out(w_flush)
    );

    function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // I-cache model: fixed-content memory with a random response latency
    int lat_min = 0;
    int lat_max = 0;
    int wcnt = 0;
    always @(negedge clk) begin
        if (!icache_req || icache_ready) begin
            icache_ready = 1'b0;
            wcnt = int'($urandom_range(lat_max, lat_min));
        end else if (wcnt == 0) begin
            icache_ready = 1'b1;
            icache_data  = mem_word(icache_addr);
        end else begin
            wcnt--;
        end
    end

    // Zero-wait cache for the wrap-around instance
    always @(negedge clk) begin
        w_ready = w_req && !w_ready;
        w_data  = mem_word(w_addr);
    end

    // Reference model: a response is delivered on the first unstalled cycle from its
    // ready onward unless a redirect hit it in flight or while held; PC advances by 4
    // per delivery and jumps to the aligned target on redirect.
    typedef struct {
        logic [W-1:0] pc;
        logic [W-1:0] ins;
    } deliv_t;
    deliv_t       exp_q[$];
    logic [W-1:0] m_pc, m_last_pc, m_last_ins, m_pend_pc;
    bit           m_pend, m_taint, m_act, m_flush;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_pc = RST_PC; m_last_pc = '0; m_last_ins = '0; m_pend_pc = '0;
            m_pend = 0; m_taint = 0; m_act = 0; m_flush = 0;
            exp_q.delete();
        end else begin
            m_act = 0;
            m_flush = 0;
            if (redirect_valid) begin
                m_flush = 1;
                m_pend  = 0;
                m_pc    = redirect_pc & ~32'h3;
                if (icache_ready)    m_taint = 0;
                else if (icache_req) m_taint = 1;
            end else begin
                if (icache_ready) begin
                    if (!m_taint) begin
                        m_pend = 1;
                        m_pend_pc = m_pc;
                    end
                    m_taint = 0;
                end
                if (m_pend && !stall) begin
                    m_act = 1;
                    m_pend = 0;
                    m_last_pc = m_pend_pc;
                    m_last_ins = mem_word(m_pend_pc);
                    exp_q.push_back('{pc: m_pend_pc, ins: mem_word(m_pend_pc)});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    // Monitor: compares DUT outputs against the model every cycle
    logic         prev_req = 1'b0;
    logic [W-1:0] prev_addr = '0;
    always @(negedge clk) begin
        deliv_t e;
        if (!rst_n) begin
            prev_req = 1'b0;
        end else begin
            check("flush_out", W'(flush_out), W'(m_flush));
            check("active_out", W'(active_out), W'(m_act));
            if (active_out) begin
                if (exp_q.size() == 0) begin
                    timeout("sb_unexpected_delivery");
                end else begin
                    e = exp_q.pop_front();
                    check("pc_out", pc_out, e.pc);
                    check("instruction_out", instruction_out, e.ins);
                end
            end else begin
                check("pc_out_hold", pc_out, m_last_pc);
                check("instr_hold", instruction_out, m_last_ins);
            end
            if (icache_req && !prev_req) check("req_addr", icache_addr, m_pc);
            if (icache_req && prev_req)  check("addr_stable", icache_addr, prev_addr);
            prev_req  = icache_req;
            prev_addr = icache_addr;
        end
    end

    // Capture the first requests/deliveries of the wrap instance
    logic [W-1:0] w_addrs[$];
    logic [W-1:0] w_pcs[$];
    logic         w_prev = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (w_req && !w_prev && w_addrs.size() < 3) w_addrs.push_back(w_addr);
            if (w_act && w_pcs.size() < 2) w_pcs.push_back(w_pc);
            w_prev = w_req;
        end else begin
            w_prev = 1'b0;
        end
    end

    initial begin
        int act_cyc[$];
        int n;

        // Reset values
        repeat (2) step();
        check("rst_req", W'(icache_req), '0);
        check("rst_addr", icache_addr, '0);
        check("rst_pc_out", pc_out, '0);
        check("rst_instr", instruction_out, '0);
        check("rst_active", W'(active_out), '0);
        check("rst_flush", W'(flush_out), '0);

        // Zero-wait cache: one delivery every two cycles from 1000
        lat_min = 0; lat_max = 0;
        rst_n = 1'b1; start = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            if (active_out) act_cyc.push_back(c);
        end
        if (act_cyc.size() < 3) timeout("t1_deliveries");
        else begin
            check("t1_gap0", W'(act_cyc[1] - act_cyc[0]), W'(2));
            check("t1_gap1", W'(act_cyc[2] - act_cyc[1]), W'(2));
        end

        // Back-pressure for five cycles
        stall = 1'b1;
        repeat (5) step();
        stall = 1'b0;
        repeat (8) step();

        // Redirect while a slow request is outstanding
        lat_min = 3; lat_max = 3;
        n = 0;
        while (!(icache_req && !icache_ready) && n < 50) begin step(); n++; end
        if (n >= 50) timeout("t3_wait_req");
        redirect_valid = 1'b1; redirect_pc = 32'h0000_2003;
        step();
        redirect_valid = 1'b0;
        repeat (14) step();

        // Redirect in the same cycle as the cache response
        lat_min = 0; lat_max = 2;
        n = 0;
        while (!icache_ready && n < 50) begin step(); n++; end
        if (n >= 50) timeout("t4_wait_ready");
        redirect_valid = 1'b1; redirect_pc = 32'h0000_3000;
        step();
        redirect_valid = 1'b0;
        repeat (8) step();

        // Redirect near the top of the address space; PC must wrap
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFD;
        step();
        redirect_valid = 1'b0;
        repeat (12) step();

        // Asynchronous reset in the middle of a request
        lat_min = 4; lat_max = 4;
        n = 0;
        while (!icache_req && n < 50) begin step(); n++; end
        if (n >= 50) timeout("t6_wait_req");
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req", W'(icache_req), '0);
        check("arst_addr", icache_addr, '0);
        check("arst_pc_out", pc_out, '0);
        check("arst_instr", instruction_out, '0);
        check("arst_active", W'(active_out), '0);
        check("arst_flush", W'(flush_out), '0);
        step();
        step();
        rst_n = 1'b1;
        n = 0;
        while (!icache_req && n < 50) begin step(); n++; end
        if (n >= 50) timeout("t6_wait_first_req");
        else check("t6_first_addr", icache_addr, RST_PC);

        // Randomized traffic
        lat_min = 0; lat_max = 3;
        for (int i = 0; i < 1500; i++) begin
            start = ($urandom_range(9, 0) != 0);
            stall = ($urandom_range(9, 0) < 3);
            redirect_valid = ($urandom_range(19, 0) == 0);
            if ($urandom_range(7, 0) == 0) redirect_pc = 32'hFFFF_FFF8 + W'($urandom_range(7, 0));
            else redirect_pc = $urandom;
            step();
        end
        start = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
        repeat (20) step();
        check("sb_empty", W'(exp_q.size()), '0);

        // Wrap-around instance
        if (w_addrs.size() < 3) timeout("wrap_reqs");
        else begin
            check("wrap_addr0", w_addrs[0], WRAP_PC);
            check("wrap_addr1", w_addrs[1], 32'h0000_0000);
            check("wrap_addr2", w_addrs[2], 32'h0000_0004);
        end
        if (w_pcs.size() < 2) timeout("wrap_deliveries");
        else begin
            check("wrap_pc0", w_pcs[0], WRAP_PC);
            check("wrap_pc1", w_pcs[1], 32'h0000_0000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
